// File: rtl/vpu_pkg.sv
// Shared VPU definitions: SRAM geometry plus the source-port arbiter state and beat types.
package vpu_pkg;

    localparam int SRAM_BANK_CNT_LG2   = 2;
    localparam int SRAM_BANK_DEPTH_LG2 = 10;
    localparam int SRAM_DATA_WIDTH     = 32;

    localparam int VPU_ARB_N_REQ_MAX   = 8;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } vpu_arb_state_t;

    typedef struct packed {
        logic [SRAM_BANK_CNT_LG2-1:0]   rid;
        logic [SRAM_BANK_DEPTH_LG2-1:0] addr;
        logic                           reb;
        logic                           rlast;
    } vpu_src_beat_t;

endpackage

// File: rtl/vpu_arb_id_fifo.sv
// Ordered FIFO of grant IDs, one entry per outstanding read beat.
module vpu_arb_id_fifo
    import vpu_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Storage needs no reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_src_port_arbiter.sv
// Round-robin, burst-locked arbiter sharing one VPU SRAM read port; in-order read data routed back by grant ID.
// Optional perf counters enabled by defining VPU_ARB_PERF_CNT_EN (ports exist in both builds).
module vpu_src_port_arbiter
    import vpu_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int OUTST_DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [N_REQ-1:0]                     m_req,
    input  logic [N_REQ*SRAM_BANK_CNT_LG2-1:0]   m_rid,
    input  logic [N_REQ*SRAM_BANK_DEPTH_LG2-1:0] m_addr,
    input  logic [N_REQ-1:0]                     m_reb,
    input  logic [N_REQ-1:0]                     m_rlast,
    output logic [N_REQ-1:0]                     m_ack,
    output logic [SRAM_DATA_WIDTH-1:0]           m_rdata,
    output logic [N_REQ-1:0]                     m_rvalid,
    output logic                                 s_req,
    output logic [SRAM_BANK_CNT_LG2-1:0]         s_rid,
    output logic [SRAM_BANK_DEPTH_LG2-1:0]       s_addr,
    output logic                                 s_reb,
    output logic                                 s_rlast,
    input  logic                                 s_ack,
    input  logic [SRAM_DATA_WIDTH-1:0]           s_rdata,
    input  logic                                 s_rvalid,
    output logic                                 err_unexp_rvalid,
    output logic [N_REQ*32-1:0]                  perf_beats,
    output logic [31:0]                          perf_full_stall
);

    localparam int IW = $clog2(N_REQ);
    localparam int RW = SRAM_BANK_CNT_LG2;
    localparam int AW = SRAM_BANK_DEPTH_LG2;

    vpu_arb_state_t           r_state, w_state_nxt;
    logic [IW-1:0]            r_gnt_id, w_gnt_nxt;
    logic [IW-1:0]            r_rr_ptr, w_rr_nxt;
    logic [IW-1:0]            w_pick, w_cand;
    logic                     w_push, w_pop;
    logic                     w_fifo_full, w_fifo_empty;
    logic [IW-1:0]            w_head;
    vpu_src_beat_t            w_beat;
    logic [N_REQ-1:0]         r_m_rvalid;
    logic [SRAM_DATA_WIDTH-1:0] r_m_rdata;
    logic                     r_err;

    // Scanning downward lets the lowest offset from rr_ptr win without an early exit.
    always_comb begin
        w_pick = r_rr_ptr;
        w_cand = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            w_cand = IW'((int'(r_rr_ptr) + i) % N_REQ);
            if (m_req[w_cand]) w_pick = w_cand;
        end
    end

    always_comb begin
        w_beat.rid   = m_rid[int'(r_gnt_id)*RW +: RW];
        w_beat.addr  = m_addr[int'(r_gnt_id)*AW +: AW];
        w_beat.reb   = m_reb[r_gnt_id];
        w_beat.rlast = m_rlast[r_gnt_id];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt_id;
        w_rr_nxt    = r_rr_ptr;
        w_push      = 1'b0;
        s_req       = 1'b0;
        s_rid       = '0;
        s_addr      = '0;
        s_reb       = 1'b1;
        s_rlast     = 1'b0;
        m_ack       = '0;
        case (r_state)
            ARB_IDLE: begin
                if (|m_req) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                s_req   = m_req[r_gnt_id] & ~w_fifo_full;
                s_rid   = w_beat.rid;
                s_addr  = w_beat.addr;
                s_reb   = w_beat.reb;
                s_rlast = w_beat.rlast;
                if (s_req && s_ack) begin
                    m_ack[r_gnt_id] = 1'b1;
                    w_push          = 1'b1;
                    if (w_beat.rlast) begin
                        w_rr_nxt    = (r_gnt_id == IW'(N_REQ-1)) ? '0 : r_gnt_id + 1'b1;
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_gnt_id <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt_id <= w_gnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    vpu_arb_id_fifo #(
        .WIDTH (IW),
        .DEPTH (OUTST_DEPTH)
    ) u_id_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (r_gnt_id),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

    assign w_pop = s_rvalid & ~w_fifo_empty;

    // A beat with nothing outstanding is flagged and dropped rather than routed anywhere.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_rvalid <= '0;
            r_m_rdata  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_m_rvalid <= '0;
            if (s_rvalid) begin
                if (w_fifo_empty) begin
                    r_err <= 1'b1;
                end else begin
                    r_m_rvalid[w_head] <= 1'b1;
                    r_m_rdata          <= s_rdata;
                end
            end
        end
    end

    assign m_rvalid         = r_m_rvalid;
    assign m_rdata          = r_m_rdata;
    assign err_unexp_rvalid = r_err;

`ifdef VPU_ARB_PERF_CNT_EN
    logic [31:0] r_perf_beats [N_REQ];
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) r_perf_beats[i] <= '0;
            r_perf_stall <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (m_ack[i] && (r_perf_beats[i] != '1)) r_perf_beats[i] <= r_perf_beats[i] + 1'b1;
            end
            if ((r_state == ARB_GRANT) && m_req[r_gnt_id] && w_fifo_full && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + 1'b1;
        end
    end

    for (genvar g = 0; g < N_REQ; g++) begin : g_perf
        assign perf_beats[g*32 +: 32] = r_perf_beats[g];
    end
    assign perf_full_stall = r_perf_stall;
`else
    assign perf_beats      = '0;
    assign perf_full_stall = '0;
`endif

endmodule

// File: tb/tb_vpu_src_port_arbiter.sv
// Self-checking bench for vpu_src_port_arbiter: directed scenarios plus random traffic against a transaction-level model.
module tb_vpu_src_port_arbiter;
    import vpu_pkg::*;

    localparam int N  = 4;
    localparam int D  = 8;
    localparam int RW = SRAM_BANK_CNT_LG2;
    localparam int AW = SRAM_BANK_DEPTH_LG2;
    localparam int DW = SRAM_DATA_WIDTH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      m_req, m_reb, m_rlast, m_ack, m_rvalid;
    logic [N*RW-1:0]   m_rid;
    logic [N*AW-1:0]   m_addr;
    logic [DW-1:0]     m_rdata, s_rdata;
    logic              s_req, s_reb, s_rlast, s_ack, s_rvalid, err_unexp_rvalid;
    logic [RW-1:0]     s_rid;
    logic [AW-1:0]     s_addr;
    logic [N*32-1:0]   perf_beats;
    logic [31:0]       perf_full_stall;

    vpu_src_port_arbiter #(.N_REQ(N), .OUTST_DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n),
        .m_req(m_req), .m_rid(m_rid), .m_addr(m_addr), .m_reb(m_reb), .m_rlast(m_rlast),
        .m_ack(m_ack), .m_rdata(m_rdata), .m_rvalid(m_rvalid),
        .s_req(s_req), .s_rid(s_rid), .s_addr(s_addr), .s_reb(s_reb), .s_rlast(s_rlast),
        .s_ack(s_ack), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
        .err_unexp_rvalid(err_unexp_rvalid),
        .perf_beats(perf_beats), .perf_full_stall(perf_full_stall)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Requester-side state: beats left in the current burst and the beat being presented.
    int          remBeats [N];
    logic [AW-1:0] curAddr [N];
    logic [RW-1:0] curRid  [N];
    logic        curReb  [N];
    int          reqProb, maxBurst, ackProb, rvProb;
    bit          unexpRv;

    // Transaction-level model: issue order of accepted beats, who owns the port, what comes back.
    int          sramQ[$];
    int          grantLog[$];
    bit          arbPending;
    int          rrPtr, owner, outstStart;
    logic [N-1:0] expRv;
    logic [DW-1:0] expData;
    bit          expErr;
    int          beatCnt [N];
    int          dutAcks [N];
    int          stallCnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic resetModel();
        for (int i = 0; i < N; i++) begin
            remBeats[i] = 0; curAddr[i] = '0; curRid[i] = '0; curReb[i] = 1'b0;
            beatCnt[i] = 0; dutAcks[i] = 0;
        end
        sramQ.delete();
        grantLog.delete();
        arbPending = 1'b1;
        rrPtr = 0; owner = 0; stallCnt = 0;
        expRv = '0; expData = '0; expErr = 1'b0;
        unexpRv = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_m_ack"}, m_ack, 0);
        check({tag, "_m_rvalid"}, m_rvalid, 0);
        check({tag, "_m_rdata"}, m_rdata, 0);
        check({tag, "_s_req"}, s_req, 0);
        check({tag, "_s_rid"}, s_rid, 0);
        check({tag, "_s_addr"}, s_addr, 0);
        check({tag, "_s_reb"}, s_reb, 1);
        check({tag, "_s_rlast"}, s_rlast, 0);
        check({tag, "_err"}, err_unexp_rvalid, 0);
        check({tag, "_perf_stall"}, perf_full_stall, 0);
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (remBeats[i] == 0 && reqProb > 0 && int'($urandom_range(99)) < reqProb) begin
                remBeats[i] = int'($urandom_range(maxBurst, 1));
                curAddr[i]  = AW'($urandom);
                curRid[i]   = RW'($urandom);
                curReb[i]   = 1'($urandom);
            end
            m_req[i]              = (remBeats[i] > 0);
            m_rid[i*RW +: RW]     = curRid[i];
            m_addr[i*AW +: AW]    = curAddr[i];
            m_reb[i]              = curReb[i];
            m_rlast[i]            = (remBeats[i] == 1);
        end
        s_ack      = (int'($urandom_range(99)) < ackProb);
        outstStart = sramQ.size();
        s_rdata    = DW'($urandom);
        s_rvalid   = unexpRv || (sramQ.size() > 0 && int'($urandom_range(99)) < rvProb);
    endtask

    task automatic checkOutput();
        logic [N-1:0] expAck;
        bit expSreq;
        int first;
        expAck = '0;
        expSreq = 1'b0;
        check("m_rvalid", m_rvalid, expRv);
        if (expRv != '0) check("m_rdata", m_rdata, expData);
        check("err_unexp_rvalid", err_unexp_rvalid, expErr);

        if (arbPending) begin
            check("bubble_s_req", s_req, 0);
            if (m_req != '0) begin
                first = -1;
                for (int k = 0; k < N; k++) begin
                    if (first < 0 && m_req[(rrPtr + k) % N]) first = (rrPtr + k) % N;
                end
                owner = first;
                arbPending = 1'b0;
            end
        end else begin
            expSreq = m_req[owner] && (outstStart < D);
            if (m_req[owner] && outstStart >= D) stallCnt++;
            check("s_req", s_req, expSreq);
            if (expSreq) begin
                check("s_rid", s_rid, curRid[owner]);
                check("s_addr", s_addr, curAddr[owner]);
                check("s_reb", s_reb, curReb[owner]);
                check("s_rlast", s_rlast, (remBeats[owner] == 1));
                if (s_ack) expAck[owner] = 1'b1;
            end
        end
        check("m_ack", m_ack, expAck);
        for (int i = 0; i < N; i++) begin
            if (m_ack[i]) begin
                dutAcks[i]++;
                grantLog.push_back(i);
            end
        end

        expRv = '0;
        if (s_rvalid) begin
            if (sramQ.size() > 0) begin
                expRv[sramQ.pop_front()] = 1'b1;
                expData = s_rdata;
            end else begin
                expErr = 1'b1;
            end
        end

        if (expAck != '0) begin
            sramQ.push_back(owner);
            beatCnt[owner]++;
            if (remBeats[owner] == 1) begin
                arbPending = 1'b1;
                rrPtr = (owner + 1) % N;
            end
            remBeats[owner]--;
            curAddr[owner] = curAddr[owner] + 1'b1;
            curReb[owner]  = 1'($urandom);
        end
    endtask

    task automatic runCycle();
        @(posedge clk);
        #1 applyStimulus();
        #4 checkOutput();
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) runCycle();
    endtask

    function automatic bit busy();
        bit b;
        b = (sramQ.size() > 0) || (expRv != '0);
        for (int i = 0; i < N; i++) if (remBeats[i] > 0) b = 1'b1;
        return b;
    endfunction

    task automatic drain(input string tag);
        int c;
        reqProb = 0; ackProb = 100; rvProb = 100;
        c = 0;
        while (busy() && c < 200) begin
            runCycle();
            c++;
        end
        check({tag, "_drained"}, busy(), 0);
    endtask

    initial begin
        int acksBefore;
        rst_n = 1'b0;
        m_req = '0; m_rid = '0; m_addr = '0; m_reb = '0; m_rlast = '0;
        s_ack = 1'b0; s_rdata = '0; s_rvalid = 1'b0;
        reqProb = 0; maxBurst = 1; ackProb = 0; rvProb = 0;
        resetModel();
        #1 checkResetValues("reset");
        #20;
        @(negedge clk) rst_n = 1'b1;

        $display("[TB] single burst");
        remBeats[0] = 3; curAddr[0] = AW'(16); curRid[0] = RW'(1); curReb[0] = 1'b0;
        ackProb = 100; rvProb = 0;
        runCycles(9);
        rvProb = 100;
        runCycles(4);
        check("single_burst_acks", dutAcks[0], 3);
        drain("single");

        $display("[TB] round robin");
        grantLog.delete();
        reqProb = 100; maxBurst = 1; ackProb = 100; rvProb = 100;
        runCycles(12);
        check("rr_enough_grants", (grantLog.size() >= 5), 1);
        for (int k = 0; k < 5 && k < grantLog.size(); k++)
            check($sformatf("rr_order_%0d", k), grantLog[k], (1 + k) % N);
        drain("rr");

        $display("[TB] burst lock");
        remBeats[1] = 4; curAddr[1] = AW'(64); curRid[1] = RW'(2);
        remBeats[2] = 1; curAddr[2] = AW'(128); curRid[2] = RW'(3);
        ackProb = 100; rvProb = 50;
        runCycles(10);
        drain("lock");

        $display("[TB] random traffic");
        reqProb = 30; maxBurst = 4; ackProb = 70; rvProb = 60;
        runCycles(300);
        rvProb = 10;
        runCycles(200);
        drain("random");

        $display("[TB] fifo full");
        acksBefore = dutAcks[0];
        remBeats[0] = 10; curAddr[0] = AW'(256);
        ackProb = 100; rvProb = 0;
        runCycles(14);
        check("full_ack_count", dutAcks[0] - acksBefore, D);
        check("full_s_req_low", s_req, 0);
        rvProb = 100;
        runCycle();
        check("full_pop_cycle_s_req", s_req, 0);
        rvProb = 0;
        runCycle();
        check("full_after_pop_s_req", s_req, 1);
        drain("full");

`ifdef VPU_ARB_PERF_CNT_EN
        for (int i = 0; i < N; i++) check($sformatf("perf_beats_%0d", i), perf_beats[i*32 +: 32], beatCnt[i]);
        check("perf_full_stall", perf_full_stall, stallCnt);
`else
        check("perf_beats_tied", perf_beats, 0);
        check("perf_full_stall_tied", perf_full_stall, 0);
`endif

        $display("[TB] unexpected rvalid");
        unexpRv = 1'b1;
        runCycle();
        unexpRv = 1'b0;
        runCycles(3);
        check("err_sticky", err_unexp_rvalid, 1);

        $display("[TB] reset mid-burst");
        remBeats[1] = 4; curAddr[1] = AW'(512);
        ackProb = 100; rvProb = 0;
        runCycles(3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("async_reset");
        resetModel();
        m_req = '0;
        s_ack = 1'b0;
        s_rvalid = 1'b0;
        #20;
        @(negedge clk) rst_n = 1'b1;
        runCycles(2);
        unexpRv = 1'b1;
        runCycle();
        unexpRv = 1'b0;
        runCycle();
        check("post_reset_fifo_empty", err_unexp_rvalid, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
